stage2_decode_hz: RTL and testbench

Parametrised decode stage (ID) for the 5-stage MIPS pipeline. It is the successor to the no-hazard decode stage.
- Contains the register file with write-through bypass from writeback.
- Decodes R/I/branch/memory/jump instructions and extends immediates.
- Detects load-use hazards, then stalls IF and injects a bubble.
- Accepts a flush from branch resolution.
- All ID/EX outputs are registered.

---
 rtl/stage2_decode_hz_pkg.sv | 78 +++++++
 rtl/stage2_decode_hz_regfile_bypass.sv | 38 +++
 rtl/stage2_decode_hz.sv | 119 +++++++++++
 tb/tb_stage2_decode_hz.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stage2_decode_hz_pkg.sv
// Shared opcode map and decoded-control record for the MIPS decode stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LDW   = 6'h01;
    localparam logic [5:0] OP_STW   = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h04;
    localparam logic [5:0] OP_SUBI  = 6'h05;
    localparam logic [5:0] OP_MULI  = 6'h06;
    localparam logic [5:0] OP_DIVI  = 6'h07;
    localparam logic [5:0] OP_ANDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h09;
    localparam logic [5:0] OP_NORI  = 6'h0A;
    localparam logic [5:0] OP_XORI  = 6'h0B;
    localparam logic [5:0] OP_BEQ   = 6'h0C;
    localparam logic [5:0] OP_BNE   = 6'h0D;
    localparam logic [5:0] OP_BLT   = 6'h0E;
    localparam logic [5:0] OP_BLE   = 6'h0F;
    localparam logic [5:0] OP_ADDHI = 6'h24;
    localparam logic [5:0] OP_SUBHI = 6'h25;
    localparam logic [5:0] OP_MULHI = 6'h26;
    localparam logic [5:0] OP_DIVHI = 6'h27;
    localparam logic [5:0] OP_ANDHI = 6'h28;
    localparam logic [5:0] OP_ORHI  = 6'h29;
    localparam logic [5:0] OP_NORHI = 6'h2A;
    localparam logic [5:0] OP_XORHI = 6'h2B;
    localparam logic [5:0] OP_JMP   = 6'h3F;

    typedef enum logic [1:0] {OP2_RT, OP2_SEXT, OP2_ZEXT, OP2_HI} op2_sel_e;
    typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT} dst_sel_e;

    typedef struct packed {
        logic     valid;
        logic     rt_src;
        op2_sel_e op2_sel;
        dst_sel_e dst_sel;
        logic     en_write;
        logic     jmp_br;
        logic     mem_read;
        logic     mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, rt_src: 1'b0, op2_sel: OP2_RT,
                                      dst_sel: DST_NONE, en_write: 1'b0, jmp_br: 1'b0,
                                      mem_read: 1'b0, mem_write: 1'b0};

    // rt_src is reported for every R-type so hazard checks stay conservative on bad functs.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_BUBBLE;
        if (op == OP_RTYPE) begin
            c.rt_src = 1'b1;
            if (funct inside {[6'h04:6'h0B], [6'h18:6'h1B]}) begin
                c.valid    = 1'b1;
                c.op2_sel  = OP2_RT;
                c.dst_sel  = DST_RD;
                c.en_write = 1'b1;
            end
        end else if (op inside {[OP_ADDI:OP_DIVI]}) begin
            c.valid = 1'b1; c.op2_sel = OP2_SEXT; c.dst_sel = DST_RT; c.en_write = 1'b1;
        end else if (op inside {[OP_ANDI:OP_XORI]}) begin
            c.valid = 1'b1; c.op2_sel = OP2_ZEXT; c.dst_sel = DST_RT; c.en_write = 1'b1;
        end else if (op inside {[OP_ADDHI:OP_XORHI]}) begin
            c.valid = 1'b1; c.op2_sel = OP2_HI; c.dst_sel = DST_RT; c.en_write = 1'b1;
        end else if (op inside {[OP_BEQ:OP_BLE]}) begin
            c.valid = 1'b1; c.rt_src = 1'b1; c.op2_sel = OP2_RT; c.jmp_br = 1'b1;
        end else if (op == OP_LDW) begin
            c.valid = 1'b1; c.op2_sel = OP2_SEXT; c.dst_sel = DST_RT;
            c.en_write = 1'b1; c.mem_read = 1'b1;
        end else if (op == OP_STW) begin
            c.valid = 1'b1; c.rt_src = 1'b1; c.op2_sel = OP2_SEXT; c.mem_write = 1'b1;
        end else if (op == OP_JMP) begin
            c.valid = 1'b1; c.op2_sel = OP2_SEXT; c.jmp_br = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/stage2_decode_hz_regfile_bypass.sv
// Register file, two read ports, one write port; reads see the value being written this cycle.
module regfile_bypass #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0]     rdata1_o,
    output logic [DATA_W-1:0]     rdata2_o,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i
);
    localparam int NREG = 2**REG_ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_live;

    assign wr_live = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_live) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) rdata1_o = (wr_live && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
        if (raddr2_i != '0) rdata2_o = (wr_live && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
    end

endmodule

// File: rtl/stage2_decode_hz.sv
// ID stage: decode, register read with writeback bypass, load-use stall and flush into ID/EX.
module stage2_decode_hz
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  En_Pipeline,
    input  logic                  flush,
    input  logic [31:0]           instruction,
    input  logic [DATA_W-1:0]     STG25_data_in,
    input  logic [REG_ADDR_W-1:0] STG25_addr_Write_Reg,
    input  logic                  STG25_En_Write_Reg,
    output logic                  stall_out,
    output logic [DATA_W-1:0]     ALU_operand1,
    output logic [DATA_W-1:0]     ALU_operand2,
    output logic [DATA_W-1:0]     Store_Data,
    output logic [DATA_W-1:0]     Imm_out,
    output logic [5:0]            opcode,
    output logic [REG_ADDR_W-1:0] Addr_Write_Reg,
    output logic                  En_Write_Reg,
    output logic                  JMP_BR_flag,
    output logic                  Mem_Read,
    output logic                  Mem_Write
);
    logic [5:0]            op_f, funct_f;
    logic [REG_ADDR_W-1:0] rs_a, rt_a, rd_a;
    logic [IMM_W-1:0]      imm_f;
    logic [DATA_W-1:0]     imm_sext, imm_zext, imm_hi, rs_val, rt_val;
    ctrl_t                 ctrl;
    logic                  hazard;

    logic [DATA_W-1:0]     op1_q, op1_d, op2_q, op2_d, sd_q, sd_d, imm_q, imm_d;
    logic [5:0]            opc_q, opc_d;
    logic [REG_ADDR_W-1:0] dst_q, dst_d;
    logic                  we_q, we_d, jb_q, jb_d, mr_q, mr_d, mw_q, mw_d;

    assign op_f     = instruction[31:26];
    assign funct_f  = instruction[5:0];
    assign rs_a     = instruction[21 +: REG_ADDR_W];
    assign rt_a     = instruction[16 +: REG_ADDR_W];
    assign rd_a     = instruction[11 +: REG_ADDR_W];
    assign imm_f    = instruction[IMM_W-1:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm_f[IMM_W-1]}}, imm_f};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm_f};
    assign imm_hi   = {imm_f, {(DATA_W-IMM_W){1'b0}}};
    assign ctrl     = decode_ctrl(op_f, funct_f);

    regfile_bypass #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs_a),
        .raddr2_i (rt_a),
        .rdata1_o (rs_val),
        .rdata2_o (rt_val),
        .we_i     (STG25_En_Write_Reg),
        .waddr_i  (STG25_addr_Write_Reg),
        .wdata_i  (STG25_data_in)
    );

    // Load in ID/EX whose destination is read here; holds while the pipe is frozen.
    assign hazard    = mr_q && (dst_q != '0) &&
                       ((dst_q == rs_a) || (ctrl.rt_src && (dst_q == rt_a)));
    assign stall_out = hazard;

    always_comb begin
        op1_d = '0; op2_d = '0; sd_d = '0; imm_d = '0;
        opc_d = '0; dst_d = '0;
        we_d  = 1'b0; jb_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0;
        if (!flush && !hazard && ctrl.valid) begin
            op1_d = rs_val;
            sd_d  = rt_val;
            imm_d = imm_sext;
            opc_d = (op_f == OP_RTYPE) ? funct_f : op_f;
            case (ctrl.op2_sel)
                OP2_SEXT: op2_d = imm_sext;
                OP2_ZEXT: op2_d = imm_zext;
                OP2_HI:   op2_d = imm_hi;
                default:  op2_d = rt_val;
            endcase
            case (ctrl.dst_sel)
                DST_RD:  dst_d = rd_a;
                DST_RT:  dst_d = rt_a;
                default: dst_d = '0;
            endcase
            we_d = ctrl.en_write;
            jb_d = ctrl.jmp_br;
            mr_d = ctrl.mem_read;
            mw_d = ctrl.mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op1_q <= '0; op2_q <= '0; sd_q <= '0; imm_q <= '0;
            opc_q <= '0; dst_q <= '0;
            we_q  <= 1'b0; jb_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0;
        end else if (En_Pipeline) begin
            op1_q <= op1_d; op2_q <= op2_d; sd_q <= sd_d; imm_q <= imm_d;
            opc_q <= opc_d; dst_q <= dst_d;
            we_q  <= we_d; jb_q <= jb_d; mr_q <= mr_d; mw_q <= mw_d;
        end
    end

    assign ALU_operand1   = op1_q;
    assign ALU_operand2   = op2_q;
    assign Store_Data     = sd_q;
    assign Imm_out        = imm_q;
    assign opcode         = opc_q;
    assign Addr_Write_Reg = dst_q;
    assign En_Write_Reg   = we_q;
    assign JMP_BR_flag    = jb_q;
    assign Mem_Read       = mr_q;
    assign Mem_Write      = mw_q;

endmodule

// File: tb/tb_stage2_decode_hz.sv
// Directed bench for stage2_decode_hz with an instruction-level reference model.
module tb_stage2_decode_hz;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset, En_Pipeline, flush;
    logic [31:0]   instruction;
    logic [DW-1:0] STG25_data_in;
    logic [AW-1:0] STG25_addr_Write_Reg;
    logic          STG25_En_Write_Reg;
    logic          stall_out;
    logic [DW-1:0] ALU_operand1, ALU_operand2, Store_Data, Imm_out;
    logic [5:0]    opcode;
    logic [AW-1:0] Addr_Write_Reg;
    logic          En_Write_Reg, JMP_BR_flag, Mem_Read, Mem_Write;

    stage2_decode_hz #(.DATA_W(DW), .REG_ADDR_W(AW), .IMM_W(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .En_Pipeline          (En_Pipeline),
        .flush                (flush),
        .instruction          (instruction),
        .STG25_data_in        (STG25_data_in),
        .STG25_addr_Write_Reg (STG25_addr_Write_Reg),
        .STG25_En_Write_Reg   (STG25_En_Write_Reg),
        .stall_out            (stall_out),
        .ALU_operand1         (ALU_operand1),
        .ALU_operand2         (ALU_operand2),
        .Store_Data           (Store_Data),
        .Imm_out              (Imm_out),
        .opcode               (opcode),
        .Addr_Write_Reg       (Addr_Write_Reg),
        .En_Write_Reg         (En_Write_Reg),
        .JMP_BR_flag          (JMP_BR_flag),
        .Mem_Read             (Mem_Read),
        .Mem_Write            (Mem_Write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] op1, op2, sd, imm;
        logic [5:0]  opc;
        logic [4:0]  dst;
        logic        we, jb, mr, mw;
    } exp_t;

    exp_t        m = '0;
    logic [31:0] m_rf [32];

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (STG25_En_Write_Reg && STG25_addr_Write_Reg == a) return STG25_data_in;
        return m_rf[a];
    endfunction

    function automatic void predict(input logic [31:0] ins, output exp_t e, output bit rt_src);
        logic [5:0]  op, fn;
        logic [31:0] s, z, rtv;
        bit          known;
        op = ins[31:26]; fn = ins[5:0];
        z = {16'h0, ins[15:0]};
        s = (ins[15] == 1'b1) ? (z - 32'h10000) : z;
        rtv = m_read(ins[20:16]);
        e = '0; rt_src = 0; known = 1;
        if (op == 0) begin
            rt_src = 1;
            if ((fn >= 4 && fn <= 11) || (fn >= 24 && fn <= 27)) begin
                e.op2 = rtv; e.dst = ins[15:11]; e.we = 1;
            end else known = 0;
        end else if (op >= 4 && op <= 7) begin
            e.op2 = s; e.dst = ins[20:16]; e.we = 1;
        end else if (op >= 8 && op <= 11) begin
            e.op2 = z; e.dst = ins[20:16]; e.we = 1;
        end else if (op >= 36 && op <= 43) begin
            e.op2 = z * 32'd65536; e.dst = ins[20:16]; e.we = 1;
        end else if (op >= 12 && op <= 15) begin
            e.op2 = rtv; e.jb = 1; rt_src = 1;
        end else if (op == 1) begin
            e.op2 = s; e.mr = 1; e.dst = ins[20:16]; e.we = 1;
        end else if (op == 2) begin
            e.op2 = s; e.mw = 1; rt_src = 1;
        end else if (op == 63) begin
            e.op2 = s; e.jb = 1;
        end else known = 0;
        if (known) begin
            e.op1 = m_read(ins[25:21]);
            e.sd  = rtv;
            e.imm = s;
            e.opc = (op == 0) ? fn : op;
        end else e = '0;
    endfunction

    function automatic bit m_hazard();
        exp_t e;
        bit   rts;
        predict(instruction, e, rts);
        return m.mr && (m.dst != 0) &&
               ((m.dst == instruction[25:21]) || (rts && m.dst == instruction[20:16]));
    endfunction

    always @(posedge clk) begin : model
        exp_t nxt;
        bit   rts, hz;
        if (reset) begin
            m = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        end else begin
            predict(instruction, nxt, rts);
            hz = m_hazard();
            if (En_Pipeline) m = (flush || hz) ? exp_t'('0) : nxt;
            if (STG25_En_Write_Reg && STG25_addr_Write_Reg != 0)
                m_rf[STG25_addr_Write_Reg] = STG25_data_in;
        end
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("m_op1",   ALU_operand1,   m.op1);
            chk("m_op2",   ALU_operand2,   m.op2);
            chk("m_store", Store_Data,     m.sd);
            chk("m_imm",   Imm_out,        m.imm);
            chk("m_opc",   opcode,         m.opc);
            chk("m_dst",   Addr_Write_Reg, m.dst);
            chk("m_ctrl",  {En_Write_Reg, JMP_BR_flag, Mem_Read, Mem_Write},
                           {m.we, m.jb, m.mr, m.mw});
            chk("m_stall", stall_out,      m_hazard());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        STG25_En_Write_Reg = en; STG25_addr_Write_Reg = a; STG25_data_in = d;
    endtask

    initial begin
        reset = 1; En_Pipeline = 1; flush = 0; instruction = 32'h0;
        wb(0, 0, 0);
        tick(); cmp_en = 1; tick();
        reset = 0;
        chk("rst_op1", ALU_operand1, 0);
        chk("rst_ctrl", {En_Write_Reg, JMP_BR_flag, Mem_Read, Mem_Write, opcode}, 0);
        chk("rst_stall", stall_out, 0);

        wb(1, 2, 2); tick();
        wb(1, 3, 3); tick();
        wb(0, 0, 0);

        instruction = 32'h00221804; tick();          // add r3 = r1 + r2
        chk("add_op1", ALU_operand1, 0);
        chk("add_op2", ALU_operand2, 2);
        chk("add_opc", opcode, 6'h04);
        chk("add_dst", Addr_Write_Reg, 3);
        chk("add_we", En_Write_Reg, 1);

        instruction = 32'h10220005; wb(1, 1, 7); tick();
        wb(0, 0, 0);
        chk("addi_bypass", ALU_operand1, 7);
        chk("addi_op2", ALU_operand2, 5);
        chk("addi_dst", Addr_Write_Reg, 2);

        instruction = 32'h90220005; tick();
        chk("addhi_op2", ALU_operand2, 32'h00050000);
        instruction = 32'h2022FFFF; tick();
        chk("andi_op2", ALU_operand2, 32'h0000FFFF);
        instruction = 32'h1022FFFF; tick();
        chk("addi_neg", ALU_operand2, 32'hFFFFFFFF);
        chk("addi_imm", Imm_out, 32'hFFFFFFFF);

        instruction = 32'h04430005; tick();          // ldw r3, 5(r2)
        chk("ldw_mr", Mem_Read, 1);
        chk("ldw_dst", Addr_Write_Reg, 3);
        instruction = 32'h00622004; #1;              // add r4 = r3 + r2
        chk("lu_stall", stall_out, 1);
        tick();
        chk("lu_bubble", {En_Write_Reg, Mem_Read, opcode, Addr_Write_Reg}, 0);
        chk("lu_release", stall_out, 0);
        tick();
        chk("lu_add_op1", ALU_operand1, 3);
        chk("lu_add_op2", ALU_operand2, 2);
        chk("lu_add_dst", Addr_Write_Reg, 4);

        instruction = 32'h30430005; flush = 1; tick();
        chk("flush_jb", JMP_BR_flag, 0);
        chk("flush_opc", opcode, 0);
        flush = 0; tick();
        chk("beq_jb", JMP_BR_flag, 1);
        chk("beq_op2", ALU_operand2, 3);
        En_Pipeline = 0; instruction = 32'h10220005;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_jb", JMP_BR_flag, 1);
            chk("hold_opc", opcode, 6'h0C);
        end
        En_Pipeline = 1;

        instruction = 32'h10050001; wb(1, 0, 32'hDEAD); tick();
        wb(0, 0, 0);
        chk("r0_bypass", ALU_operand1, 0);
        tick();
        chk("r0_read", ALU_operand1, 0);

        instruction = 32'h08430004; tick();          // stw r3, 4(r2)
        chk("stw_mw", Mem_Write, 1);
        chk("stw_sd", Store_Data, 3);
        instruction = 32'hFC000010; tick();          // jmp
        chk("jmp_imm", Imm_out, 32'h10);
        instruction = 32'h4C000000; tick();          // unknown opcode 0x13
        chk("unk_we", En_Write_Reg, 0);

        instruction = 32'h04430005; tick();
        instruction = 32'h00622004; #1;
        chk("rs_stall", stall_out, 1);
        En_Pipeline = 0; tick();
        chk("frozen_stall", stall_out, 1);
        En_Pipeline = 1; reset = 1; tick();
        chk("rs_outputs", {ALU_operand2, En_Write_Reg, Mem_Read, Addr_Write_Reg}, 0);
        chk("rs_stall_clr", stall_out, 0);
        reset = 0; tick();
        chk("post_rst_dst", Addr_Write_Reg, 4);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
